dvp_capture_stream: RTL
=======================

Name: dvp_capture_stream

Overview:
- Parametrised next-generation DVP camera capture block; runs entirely in the system clock domain.
- Oversamples the camera PCLK, VSYNC, HREF and data bus through synchronisers.
- Assembles 1..N-byte pixels and emits a pixel stream with start-of-frame and end-of-line markers.
- Sits between the camera pins and the pixel FIFO; adds line/frame geometry checks, frame counters and a capture enable.

Parameters:
- DATA_W, 8, DVP data bus width in bits.
- BYTES_PER_PIX, 2, bus beats per pixel (1..4); beat 0 lands in the MSBs of pix_data.
- H_ACTIVE, 640, expected pixels per line.
- V_ACTIVE, 480, expected lines per frame.
- CNT_W, 12, width of the pixel and line counters (must hold H_ACTIVE and V_ACTIVE).
- SYNC_STAGES, 2, synchroniser depth for PCLK, VSYNC, HREF and DVP_data (>=2).
- SKIP_N, 2, capture one frame in SKIP_N (used only with DVP_FRAME_SKIP_EN).

Ports:
- sclk  in  1  system clock; must be >= 4x PCLK.
- rst  in  1  synchronous reset, active-high.
- capture_en  in  1  enable; sampled only at frame start.
- PCLK  in  1  camera pixel clock (treated as data).
- VSYNC  in  1  camera frame sync, active-high.
- HREF  in  1  camera line valid, active-high.
- DVP_data  in  DATA_W  camera data bus.
- pix_valid  out  1  one-sclk pulse per assembled pixel.
- pix_data  out  BYTES_PER_PIX*DATA_W  assembled pixel.
- pix_sof  out  1  high with pix_valid on the first pixel of a frame.
- pix_eol  out  1  high with pix_valid on the pixel whose count reaches H_ACTIVE.
- frame_done  out  1  one-cycle pulse when a captured frame ends.
- line_len_err  out  1  sticky: a line ended with pixel count != H_ACTIVE.
- frame_err  out  1  sticky: a frame ended with line count != V_ACTIVE.
- frame_cnt  out  16  count of captured frames; wraps 0xFFFF->0.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counters 0; synchroniser and assembly registers 0.
- Sampling:
  - PCLK, VSYNC, HREF and DVP_data all pass through SYNC_STAGES flops, keeping their alignment.
  - PCLK rising edge (pe) = synced PCLK 1 and previous 0.
  - VSYNC and HREF edges are detected on their synced copies.
- Byte assembly:
  - On pe with synced HREF=1 and FSM=ACTIVE, the beat is shifted into the assembly register and the beat counter increments.
  - When the beat counter reaches BYTES_PER_PIX-1, pix_valid pulses on the next sclk. pix_data is held until the next pixel.
  - Latency: 1 sclk from the detected pe of the last beat.
- Line handling:
  - HREF rise clears the beat counter and the pixel counter.
  - HREF fall with a partial pixel (beat counter != 0) discards those beats; no pix_valid.
  - HREF fall checks the pixel count against H_ACTIVE; a mismatch sets line_len_err. The line counter increments.
- pix_eol asserts only when the pixel count reaches exactly H_ACTIVE; pixels beyond H_ACTIVE are still output, with pix_eol=0.
- FSM states:
  - IDLE: wait for a synced VSYNC rise -> ARM.
  - ARM: on VSYNC fall, if capture_en -> ACTIVE (clear line counter, set first-pixel flag), else -> SKIP.
  - ACTIVE: emit pixels; VSYNC rise -> END.
  - SKIP: no outputs; VSYNC rise -> ARM.
  - END: for one cycle, frame_done=1, frame_cnt+1, check line count against V_ACTIVE (mismatch sets frame_err); -> ARM.
- pix_sof equals the first-pixel flag ANDed with pix_valid; the flag clears after that pixel.
- capture_en deasserting mid-frame has no effect until the next ARM.
- HREF rise while in IDLE, ARM or SKIP is ignored.
- line_len_err and frame_err clear only on rst.
- Counters saturate at 2^CNT_W-1; no wrap.
- rst mid-frame: everything returns to reset values; capture resumes from the next VSYNC rise.

Optional Feature:
- Macro: DVP_FRAME_SKIP_EN.
- Defined: a skip counter (0..SKIP_N-1) advances at every ARM exit. The ARM -> ACTIVE transition additionally requires the skip counter to be 0; otherwise the FSM goes to SKIP. frame_cnt counts captured frames only.
- Undefined: SKIP_N is ignored and every enabled frame is captured.

Test Plan:
- Bench parameters: DATA_W=8, BYTES_PER_PIX=2, H_ACTIVE=4, V_ACTIVE=2, PCLK = sclk/4.
- Frame of 2 lines x 8 bytes, bytes 0x11..0x88 -> pix_data 0x1122, 0x3344, 0x5566, 0x7788 each line. pix_sof on the first 0x1122 only; pix_eol on each 0x7788. frame_done pulses once; frame_cnt=1; no errors.
- Line of 7 bytes -> 3 pixels output, last byte dropped; line_len_err=1 at HREF fall; frame_err stays 0.
- Frame with 3 lines -> frame_err=1 at END; 3 pix_eol pulses seen; frame_cnt increments.
- capture_en=0 during ARM, then 1 mid-frame -> no pix_valid for that frame; the next frame is captured normally.
- rst pulsed in the middle of line 1 -> all outputs 0 next cycle; the following full frame is captured correctly with frame_cnt=1.
- With DVP_FRAME_SKIP_EN, SKIP_N=2, 4 frames -> frames 1 and 3 captured, frame_cnt=2, exactly 2 frame_done pulses.

Source files
------------

// File: rtl/dvp_capture_stream.sv
// DVP camera capture: oversamples PCLK/VSYNC/HREF/data in the sclk domain and emits an assembled pixel stream.
// Optional build macro DVP_FRAME_SKIP_EN captures only one frame in every SKIP_N.
module dvp_capture_stream #(
    parameter int DATA_W        = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int H_ACTIVE      = 640,
    parameter int V_ACTIVE      = 480,
    parameter int CNT_W         = 12,
    parameter int SYNC_STAGES   = 2,
    parameter int SKIP_N        = 2
) (
    input  logic                            sclk,
    input  logic                            rst,
    input  logic                            capture_en,
    input  logic                            PCLK,
    input  logic                            VSYNC,
    input  logic                            HREF,
    input  logic [DATA_W-1:0]               DVP_data,
    output logic                            pix_valid,
    output logic [BYTES_PER_PIX*DATA_W-1:0] pix_data,
    output logic                            pix_sof,
    output logic                            pix_eol,
    output logic                            frame_done,
    output logic                            line_len_err,
    output logic                            frame_err,
    output logic [15:0]                     frame_cnt
);

    localparam int                PIX_W     = BYTES_PER_PIX * DATA_W;
    localparam int                BEAT_W    = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BYTES_PER_PIX - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]  H_ACT_C   = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0]  V_ACT_C   = CNT_W'(V_ACTIVE);

    if (SYNC_STAGES < 2 || BYTES_PER_PIX < 1 || BYTES_PER_PIX > 4 || SKIP_N < 1) begin : g_bad_params
        $error("dvp_capture_stream: parameter out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_ACTIVE,
        ST_SKIP,
        ST_END
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] pclk_sync;
    logic [SYNC_STAGES-1:0] vsync_sync;
    logic [SYNC_STAGES-1:0] href_sync;
    logic [DATA_W-1:0]      data_sync [SYNC_STAGES];

    logic              pclk_s;
    logic              vsync_s;
    logic              href_s;
    logic [DATA_W-1:0] data_s;
    logic              pclk_d;
    logic              vsync_d;
    logic              href_d;

    logic pclk_rise;
    logic vsync_rise;
    logic vsync_fall;
    logic href_rise;
    logic href_fall;

    logic              arm_exit;
    logic              capture_ok;
    logic              beat_take;
    logic              last_beat;
    logic [BEAT_W-1:0] beat_cnt;
    logic [BEAT_W-1:0] beat_base;
    logic [CNT_W-1:0]  pix_cnt;
    logic [CNT_W-1:0]  pix_base;
    logic [CNT_W-1:0]  pix_inc;
    logic [CNT_W-1:0]  line_cnt;
    logic [PIX_W-1:0]  asm_next;
    logic              first_pix;

    // All four camera inputs share one pipeline depth so data stays aligned to its PCLK edge.
    always_ff @(posedge sclk) begin
        if (rst) begin
            pclk_sync  <= '0;
            vsync_sync <= '0;
            href_sync  <= '0;
            // NOTE: the data synchroniser is a register array, not RAM, so it is reset like any other flop.
            for (int i = 0; i < SYNC_STAGES; i++) begin
                data_sync[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage sample the previous stage's old value.
            pclk_sync  <= {pclk_sync[SYNC_STAGES-2:0], PCLK};
            vsync_sync <= {vsync_sync[SYNC_STAGES-2:0], VSYNC};
            href_sync  <= {href_sync[SYNC_STAGES-2:0], HREF};
            data_sync[0] <= DVP_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                data_sync[i] <= data_sync[i-1];
            end
        end
    end

    assign pclk_s  = pclk_sync[SYNC_STAGES-1];
    assign vsync_s = vsync_sync[SYNC_STAGES-1];
    assign href_s  = href_sync[SYNC_STAGES-1];
    assign data_s  = data_sync[SYNC_STAGES-1];

    always_ff @(posedge sclk) begin
        if (rst) begin
            pclk_d  <= 1'b0;
            vsync_d <= 1'b0;
            href_d  <= 1'b0;
        end else begin
            pclk_d  <= pclk_s;
            vsync_d <= vsync_s;
            href_d  <= href_s;
        end
    end

    assign pclk_rise  = pclk_s & ~pclk_d;
    assign vsync_rise = vsync_s & ~vsync_d;
    assign vsync_fall = ~vsync_s & vsync_d;
    assign href_rise  = href_s & ~href_d;
    assign href_fall  = ~href_s & href_d;

    assign arm_exit = (state == ST_ARM) && vsync_fall;

`ifdef DVP_FRAME_SKIP_EN
    localparam int SKIP_W = (SKIP_N > 1) ? $clog2(SKIP_N) : 1;
    logic [SKIP_W-1:0] skip_cnt;

    always_ff @(posedge sclk) begin
        if (rst) begin
            skip_cnt <= '0;
        end else if (arm_exit) begin
            skip_cnt <= (skip_cnt == SKIP_W'(SKIP_N - 1)) ? '0 : skip_cnt + 1'b1;
        end
    end

    assign capture_ok = capture_en && (skip_cnt == '0);
`else
    assign capture_ok = capture_en;
`endif

    always_ff @(posedge sclk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_nxt unassigned (no latch).
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (vsync_rise) state_nxt = ST_ARM;
            ST_ARM:    if (vsync_fall) state_nxt = capture_ok ? ST_ACTIVE : ST_SKIP;
            ST_ACTIVE: if (vsync_rise) state_nxt = ST_END;
            ST_SKIP:   if (vsync_rise) state_nxt = ST_ARM;
            ST_END:    state_nxt = ST_ARM;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    assign frame_done = (state == ST_END);

    // A beat on the same cycle as the HREF rise starts a fresh line rather than continuing the old one.
    assign beat_base = href_rise ? '0 : beat_cnt;
    assign pix_base  = href_rise ? '0 : pix_cnt;
    assign pix_inc   = (pix_base == CNT_MAX) ? pix_base : pix_base + 1'b1;
    assign beat_take = (state == ST_ACTIVE) && pclk_rise && href_s;
    assign last_beat = (beat_base == BEAT_LAST);

    generate
        if (BYTES_PER_PIX == 1) begin : g_single_beat
            assign asm_next = data_s;
        end else begin : g_multi_beat
            localparam int HOLD_W = PIX_W - DATA_W;
            logic [HOLD_W-1:0] hold_q;

            assign asm_next = {hold_q, data_s};

            always_ff @(posedge sclk) begin
                if (rst) begin
                    hold_q <= '0;
                end else if (beat_take) begin
                    hold_q <= asm_next[HOLD_W-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge sclk) begin
        if (rst) begin
            pix_valid    <= 1'b0;
            pix_data     <= '0;
            pix_sof      <= 1'b0;
            pix_eol      <= 1'b0;
            line_len_err <= 1'b0;
            frame_err    <= 1'b0;
            frame_cnt    <= '0;
            beat_cnt     <= '0;
            pix_cnt      <= '0;
            line_cnt     <= '0;
            first_pix    <= 1'b0;
        end else begin
            pix_valid <= 1'b0;
            pix_sof   <= 1'b0;
            pix_eol   <= 1'b0;

            if (state == ST_ACTIVE) begin
                if (href_rise) begin
                    beat_cnt <= '0;
                    pix_cnt  <= '0;
                end
                if (beat_take) begin
                    if (last_beat) begin
                        beat_cnt  <= '0;
                        pix_cnt   <= pix_inc;
                        pix_valid <= 1'b1;
                        pix_data  <= asm_next;
                        pix_sof   <= first_pix;
                        pix_eol   <= (pix_inc == H_ACT_C) && (pix_base != H_ACT_C);
                        first_pix <= 1'b0;
                    end else begin
                        beat_cnt <= beat_base + 1'b1;
                    end
                end
                // Leftover beats of a partial pixel are dropped by clearing the beat counter.
                if (href_fall) begin
                    beat_cnt <= '0;
                    if (pix_cnt != H_ACT_C) begin
                        line_len_err <= 1'b1;
                    end
                    if (line_cnt != CNT_MAX) begin
                        line_cnt <= line_cnt + 1'b1;
                    end
                end
            end

            if (arm_exit && capture_ok) begin
                line_cnt  <= '0;
                first_pix <= 1'b1;
            end

            if (state == ST_END) begin
                frame_cnt <= frame_cnt + 16'd1;
                if (line_cnt != V_ACT_C) begin
                    frame_err <= 1'b1;
                end
            end
        end
    end

endmodule
